pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that succeeds the fixed-field inter-stage latch.
- Carries an opaque data payload (pc, register indices, immediates, operands) and a separate control-bit vector (save_to_reg, wr_memory, …).
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so downstream stalls do not create a combinational ready path.
- A synchronous flush turns the stage into a bubble with all control bits cleared.
- Instantiated between each pair of core pipeline stages.

Parameters:
DATA_W, 64, payload width in bits (>=1)
CTRL_W, 8, control-bit width in bits (>=1); forced to zero on bubbles
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
stg_clk  in  1  stage clock, rising edge
reset_n  in  1  asynchronous reset, active low
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  entry presented downstream
out_ready  in  1  downstream accepts an entry
out_data  out  DATA_W  payload of the head entry
out_ctrl  out  CTRL_W  control bits of the head entry; 0 when out_valid=0

Behaviour:
- Definitions:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - Storage: main register M (drives out_*) and, when SKID=1, skid register S; each has a valid bit.
- Reset (reset_n=0, asynchronous, also mid-operation):
  - M and S valid bits = 0.
  - out_valid=0, out_data=0, out_ctrl=0.
  - S contents = 0.
  - in_ready=1 once reset is released.
- Latency and throughput:
  - Latency is 1 cycle from input fire to out_valid.
  - Throughput is 1 entry/cycle while out_ready=1 (both SKID modes).
- SKID=1:
  - in_ready = !S_valid, taken straight from a flop.
  - States: EMPTY (M0,S0), ONE (M1,S0), FULL (M1,S1).
  - EMPTY:
    - Input fire -> ONE, M<=in.
  - ONE:
    - Input and output fire together -> ONE, M<=in.
    - Input fire only -> FULL, S<=in.
    - Output fire only -> EMPTY.
    - Neither -> hold.
  - FULL (in_ready=0):
    - Output fire -> ONE, M<=S, S cleared.
    - Otherwise hold.
- SKID=0:
  - in_ready = !M_valid | out_ready (combinational).
  - Input fire -> M<=in.
  - Output fire without input fire -> M_valid<=0.
- Ordering and stability:
  - Entries leave in arrival order; none is duplicated or dropped, except by flush.
  - While out_valid=1 and out_ready=0, out_data and out_ctrl are held stable.
- Flush (synchronous, highest priority):
  - Next state is EMPTY.
  - out_ctrl<=0, out_valid<=0.
  - out_data keeps its last value (don't-care for consumers).
  - An input fire in the flush cycle is accepted by the handshake but discarded.
  - An output fire in the flush cycle completes normally.
  - in_ready=1 in the cycle after flush.
- Bubble rule: whenever M goes invalid, its control field is written 0. out_ctrl is therefore always 0 when out_valid=0.
- in_valid=1 with in_ready=0: upstream must hold in_data and in_ctrl; the stage does not sample them.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt [31:0]: counts cycles with out_valid=1 and out_ready=0.
  - flush_cnt [15:0]: counts flush cycles in which at least one valid entry is discarded. Output-fired entries and inputs accepted in the flush cycle do not count.
- Both counters saturate at all-ones, are cleared to 0 by reset_n, and are not cleared by flush.
- When not defined, these ports and counters do not exist, and the block's timing and area are unchanged.

Test Plan:
1. Hold out_ready=1, stream in_data=1,2,3,4 on consecutive cycles with in_ctrl=8'hA5 -> out_data=1,2,3,4 on the following four cycles, out_valid steady 1, in_ready steady 1, out_ctrl=8'hA5.
2. SKID=1: send A=0x11, then B=0x22 with out_ready=0 -> FULL, in_ready=0, out_data=0x11 stable for 5 cycles. Raise out_ready -> 0x11 then 0x22 delivered, then out_valid=0 and out_ctrl=0.
3. SKID=1 in ONE with M=0x33: present 0x44 with out_ready=1 in the same cycle -> next cycle out_data=0x44, state stays ONE, in_ready=1.
4. In FULL, assert flush=1 for one cycle while in_valid=1 with data 0x55 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x55 never appears at the output.
5. Pull reset_n low mid-stream with out_valid=1 -> out_valid, out_data and out_ctrl go to 0 before the next stg_clk edge. After release, the first input appears 1 cycle after its fire.
6. With PIPE_STAGE_PERF_EN: 3 cycles of out_valid=1 with out_ready=0, then a flush while valid -> stall_cnt=3, flush_cnt=1. A flush while EMPTY leaves flush_cnt=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload + control bits behind a valid/ready handshake,
// optional 2-entry skid buffer (SKID=1), synchronous flush. Define PIPE_STAGE_PERF_EN for stall/flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              stg_clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic              in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    // Skid mode drives in_ready from a dedicated flop to cut the backward path.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!m_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = m_valid_q && out_ready;

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;

    always_comb begin
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_ctrl_d   = m_ctrl_q;
        s_valid_d  = s_valid_q;
        s_data_d   = s_data_q;
        s_ctrl_d   = s_ctrl_q;
        in_ready_d = 1'b1;

        if (flush) begin
            // Payload of M is left as-is; only valid and control are killed.
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_ctrl_d  = '0;
        end else if (SKID != 0) begin
            case ({m_valid_q, s_valid_q})
                2'b00: begin
                    if (in_fire) begin
                        m_valid_d = 1'b1;
                        m_data_d  = in_data;
                        m_ctrl_d  = in_ctrl;
                    end
                end
                2'b10: begin
                    if (in_fire && out_fire) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        s_valid_d = 1'b1;
                        s_data_d  = in_data;
                        s_ctrl_d  = in_ctrl;
                    end else if (out_fire) begin
                        m_valid_d = 1'b0;
                        m_ctrl_d  = '0;
                    end
                end
                2'b11: begin
                    if (out_fire) begin
                        m_data_d  = s_data_q;
                        m_ctrl_d  = s_ctrl_q;
                        s_valid_d = 1'b0;
                        s_data_d  = '0;
                        s_ctrl_d  = '0;
                    end
                end
                default: begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                    s_valid_d = 1'b0;
                end
            endcase
        end else begin
            if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end

        if (SKID != 0) begin
            in_ready_d = !s_valid_d;
        end
    end

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_ctrl_q   <= '0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        stall_now;
    logic        flush_drop;

    assign stall_now  = m_valid_q && !out_ready;
    // An entry is lost only if it was still held after any output fire this cycle.
    assign flush_drop = flush && ((m_valid_q && !out_ready) || s_valid_q);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_now && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_drop && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
